// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Arbitrates the single register-file write port between the writeback
//   stage (WB, always wins when it has a real write) and a queued
//   long-latency result source (EXT). EXT results wait in a small FIFO and
//   drain in idle WB slots. If the FIFO head is blocked for STARVE_LIMIT
//   cycles, a one-cycle registered wb_stall forces a drain slot.
//   Decode can query the queued destinations through pend_hit1/pend_hit2.
//
//   Optional build macro: REGARB_STATS_EN adds the stat_stall_cnt and
//   stat_ext_wr counters and their output ports.

module regfile_wr_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_wr,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        ext_valid,
  output logic        ext_ready,
  input  logic [4:0]  ext_addr,
  input  logic [31:0] ext_data,
  output logic        wb_stall,
  input  logic [4:0]  chk_addr1,
  input  logic [4:0]  chk_addr2,
  output logic        pend_hit1,
  output logic        pend_hit2,
  output logic        rf_wr,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data
`ifdef REGARB_STATS_EN
  ,
  output logic [31:0] stat_stall_cnt,
  output logic [31:0] stat_ext_wr
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_TC  = SW'(STARVE_LIMIT - 1);

  logic [4:0]    q_addr [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic empty;
  logic full;
  logic wb_eff;
  logic pop;
  logic push;
  logic head_blocked;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // EXT is refused while full even if the head drains this cycle; no pass-through.
  assign ext_ready = !full && !reset;

  // A write to $0 or a write presented during a forced stall is not a real WB write.
  assign wb_eff = wb_wr && (wb_addr != 5'd0) && !wb_stall && !reset;

  assign pop          = !wb_eff && !empty && !reset;
  assign head_blocked = wb_eff && !empty;

  // Results for $0 complete the handshake but are never stored.
  assign push = ext_valid && ext_ready && (ext_addr != 5'd0);

  // Write-port mux: WB first, then the FIFO head, otherwise quiet zeros.
  always_comb begin
    rf_wr   = 1'b0;
    rf_addr = 5'd0;
    rf_data = 32'd0;
    if (wb_eff) begin
      rf_wr   = 1'b1;
      rf_addr = wb_addr;
      rf_data = wb_data;
    end else if (pop) begin
      rf_wr   = 1'b1;
      rf_addr = q_addr[rd_ptr];
      rf_data = q_data[rd_ptr];
    end
  end

  // Pending-destination lookup over the occupied slots, oldest first.
  always_comb begin
    pend_hit1 = 1'b0;
    pend_hit2 = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) begin
        if ((chk_addr1 != 5'd0) && (q_addr[rd_ptr + AW'(k)] == chk_addr1))
          pend_hit1 = 1'b1;
        if ((chk_addr2 != 5'd0) && (q_addr[rd_ptr + AW'(k)] == chk_addr2))
          pend_hit2 = 1'b1;
      end
    end
  end

  // FIFO payload storage; contents are don't-care until the slot is counted.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= ext_addr;
      q_data[wr_ptr] <= ext_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Counts consecutive cycles the current head has been held off by WB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      starve_cnt <= '0;
    else if (empty || pop)
      starve_cnt <= '0;
    else if (starve_cnt != STARVE_MAX)
      starve_cnt <= starve_cnt + SW'(1);
  end

  // One-cycle stall after the head has been blocked STARVE_LIMIT times in a row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wb_stall <= 1'b0;
    else
      wb_stall <= head_blocked && (starve_cnt == STARVE_TC);
  end

`ifdef REGARB_STATS_EN
  // Free-running statistics, wrapping at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_stall_cnt <= 32'd0;
      stat_ext_wr    <= 32'd0;
    end else begin
      if (wb_stall)
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      if (pop)
        stat_ext_wr <= stat_ext_wr + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Testbench for regfile_wr_arbiter: directed scenarios plus random traffic,
// all checked against a queue-based reference model.

module tb_regfile_wr_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_wr = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        ext_valid = 1'b0;
  logic        ext_ready;
  logic [4:0]  ext_addr = '0;
  logic [31:0] ext_data = '0;
  logic        wb_stall;
  logic [4:0]  chk_addr1 = '0;
  logic [4:0]  chk_addr2 = '0;
  logic        pend_hit1;
  logic        pend_hit2;
  logic        rf_wr;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
`ifdef REGARB_STATS_EN
  logic [31:0] stat_stall_cnt;
  logic [31:0] stat_ext_wr;
`endif

  regfile_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_wr     (wb_wr),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .ext_valid (ext_valid),
    .ext_ready (ext_ready),
    .ext_addr  (ext_addr),
    .ext_data  (ext_data),
    .wb_stall  (wb_stall),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .pend_hit1 (pend_hit1),
    .pend_hit2 (pend_hit2),
    .rf_wr     (rf_wr),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data)
`ifdef REGARB_STATS_EN
    ,
    .stat_stall_cnt (stat_stall_cnt),
    .stat_ext_wr    (stat_ext_wr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  // reference model state
  ent_t mq[$];
  bit   m_stall;
  int   m_wait;
  int   m_stall_cnt;
  int   m_pop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic        last_wr;
  logic [4:0]  last_addr;
  logic [31:0] last_data;
  logic        last_ready;
  logic        last_stall;
  logic        last_hit1;
  logic        last_hit2;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_stall     = 1'b0;
    m_wait      = 0;
    m_stall_cnt = 0;
    m_pop_cnt   = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic cycle(input logic i_wb, input logic [4:0] i_wa, input logic [31:0] i_wd,
                       input logic i_ev, input logic [4:0] i_ea, input logic [31:0] i_ed,
                       input logic [4:0] i_c1, input logic [4:0] i_c2);
    bit          wb_go;
    bit          e_ready;
    bit          e_wr;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    bit          e_hit1;
    bit          e_hit2;
    bit          popped;
    bit          blocked;
    ent_t        e;
    @(negedge clk);
    wb_wr = i_wb; wb_addr = i_wa; wb_data = i_wd;
    ext_valid = i_ev; ext_addr = i_ea; ext_data = i_ed;
    chk_addr1 = i_c1; chk_addr2 = i_c2;
    #1;
    wb_go   = i_wb && (i_wa != 0) && !m_stall;
    e_ready = mq.size() < DEPTH;
    e_wr = 1'b0; e_addr = '0; e_data = '0;
    if (wb_go) begin
      e_wr = 1'b1; e_addr = i_wa; e_data = i_wd;
    end else if (mq.size() > 0) begin
      e_wr = 1'b1; e_addr = mq[0].a; e_data = mq[0].d;
    end
    e_hit1 = 1'b0; e_hit2 = 1'b0;
    foreach (mq[i]) begin
      if (i_c1 != 0 && mq[i].a == i_c1) e_hit1 = 1'b1;
      if (i_c2 != 0 && mq[i].a == i_c2) e_hit2 = 1'b1;
    end
    check_val("rf_wr",     32'(rf_wr),     32'(e_wr));
    check_val("rf_addr",   32'(rf_addr),   32'(e_addr));
    check_val("rf_data",   rf_data,        e_data);
    check_val("ext_ready", 32'(ext_ready), 32'(e_ready));
    check_val("wb_stall",  32'(wb_stall),  32'(m_stall));
    check_val("pend_hit1", 32'(pend_hit1), 32'(e_hit1));
    check_val("pend_hit2", 32'(pend_hit2), 32'(e_hit2));
`ifdef REGARB_STATS_EN
    check_val("stat_stall_cnt", stat_stall_cnt, 32'(m_stall_cnt));
    check_val("stat_ext_wr",    stat_ext_wr,    32'(m_pop_cnt));
`endif
    last_wr = rf_wr; last_addr = rf_addr; last_data = rf_data;
    last_ready = ext_ready; last_stall = wb_stall;
    last_hit1 = pend_hit1; last_hit2 = pend_hit2;

    popped  = !wb_go && mq.size() > 0;
    blocked = wb_go && mq.size() > 0;
    if (m_stall) m_stall_cnt++;
    if (popped) m_pop_cnt++;
    m_stall = blocked && (m_wait == STARVE_LIMIT - 1);
    if (mq.size() == 0 || popped) m_wait = 0;
    else if (m_wait < STARVE_LIMIT) m_wait++;
    if (popped) void'(mq.pop_front());
    if (i_ev && e_ready && i_ea != 0) begin
      e.a = i_ea; e.d = i_ed;
      mq.push_back(e);
    end
  endtask

  task automatic do_reset(input logic [4:0] c1);
    @(negedge clk);
    reset = 1'b1;
    wb_wr = 1'b0; ext_valid = 1'b0;
    chk_addr1 = c1; chk_addr2 = c1;
    #1;
    check_val("rst_rf_wr",     32'(rf_wr),     32'd0);
    check_val("rst_ext_ready", 32'(ext_ready), 32'd0);
    check_val("rst_wb_stall",  32'(wb_stall),  32'd0);
    check_val("rst_pend_hit1", 32'(pend_hit1), 32'd0);
    check_val("rst_pend_hit2", 32'(pend_hit2), 32'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle(input logic [4:0] c1);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, c1, 5'd0);
  endtask

  initial begin
    model_clear();
    do_reset(5'd0);

    // 1: single EXT result drains in the next idle slot
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hA5, 5'd5, 5'd0);
    check_val("s1_hit_before", 32'(last_hit1), 32'd0);
    idle(5'd5);
    check_val("s1_rf_wr",   32'(last_wr),   32'd1);
    check_val("s1_rf_addr", 32'(last_addr), 32'd5);
    check_val("s1_rf_data", last_data,      32'hA5);
    check_val("s1_hit",     32'(last_hit1), 32'd1);
    idle(5'd5);
    check_val("s1_hit_after", 32'(last_hit1), 32'd0);

    // 2: continuous WB traffic starves the queue until forced stalls
    do_reset(5'd0);
    cycle(1'b1, 5'd7, 32'h77, 1'b1, 5'd3, 32'h33, 5'd3, 5'd4);
    cycle(1'b1, 5'd7, 32'h77, 1'b1, 5'd4, 32'h44, 5'd3, 5'd4);
    cycle(1'b1, 5'd7, 32'h77, 1'b1, 5'd5, 32'h55, 5'd3, 5'd4);
    check_val("s2_full_ready", 32'(last_ready), 32'd0);
    check_val("s2_wb_wins",    32'(last_addr),  32'd7);
    repeat (2) cycle(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4);
    check_val("s2_no_stall_yet", 32'(last_stall), 32'd0);
    cycle(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4);
    check_val("s2_stall1",   32'(last_stall), 32'd1);
    check_val("s2_r3_addr",  32'(last_addr),  32'd3);
    check_val("s2_r3_data",  last_data,       32'h33);
    repeat (4) cycle(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4);
    check_val("s2_no_stall2", 32'(last_stall), 32'd0);
    cycle(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4);
    check_val("s2_stall2",  32'(last_stall), 32'd1);
    check_val("s2_r4_addr", 32'(last_addr),  32'd4);
    cycle(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4);
    check_val("s2_after_stall", 32'(last_stall), 32'd0);
`ifdef REGARB_STATS_EN
    check_val("s2_stat_stall", stat_stall_cnt, 32'd2);
    check_val("s2_stat_ext",   stat_ext_wr,    32'd2);
`endif

    // 3: WB beats a waiting head; head drains on the first idle slot
    do_reset(5'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66, 5'd6, 5'd0);
    cycle(1'b1, 5'd2, 32'h11, 1'b0, 5'd0, 32'd0, 5'd6, 5'd0);
    check_val("s3_wb_addr", 32'(last_addr), 32'd2);
    check_val("s3_wb_data", last_data,      32'h11);
    check_val("s3_hit",     32'(last_hit1), 32'd1);
    idle(5'd6);
    check_val("s3_drain", 32'(last_addr), 32'd6);

    // 4: WB to $0 is an idle slot; EXT to $0 is accepted but not stored
    do_reset(5'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 5'd9, 5'd0);
    cycle(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
    check_val("s4_zero_wb_wr",   32'(last_wr),   32'd1);
    check_val("s4_zero_wb_addr", 32'(last_addr), 32'd9);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0);
    check_val("s4_zero_ext_ready", 32'(last_ready), 32'd1);
    idle(5'd0);
    check_val("s4_zero_ext_nowr", 32'(last_wr), 32'd0);

    // 5: full + pop + ext_valid refuses EXT; reset discards the queue
    do_reset(5'd0);
    cycle(1'b1, 5'd7, 32'h70, 1'b1, 5'd10, 32'hA0, 5'd0, 5'd0);
    cycle(1'b1, 5'd7, 32'h71, 1'b1, 5'd11, 32'hB0, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'd0,  1'b1, 5'd12, 32'hC0, 5'd12, 5'd11);
    check_val("s5_full_pop_ready", 32'(last_ready), 32'd0);
    check_val("s5_pop_addr",       32'(last_addr),  32'd10);
    cycle(1'b1, 5'd7, 32'h72, 1'b0, 5'd0, 32'd0, 5'd12, 5'd11);
    check_val("s5_r12_absent", 32'(last_hit1), 32'd0);
    check_val("s5_r11_queued", 32'(last_hit2), 32'd1);
    do_reset(5'd11);
    idle(5'd11);
    check_val("s5_lost_wr",  32'(last_wr),   32'd0);
    check_val("s5_lost_hit", 32'(last_hit1), 32'd0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(5'($urandom_range(0, 7)));
      end else begin
        cycle(1'($urandom_range(0, 99) < 65), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
